// File: rtl/branch_resolve_btb_pkg.sv
// Shared types and constants for the EX-stage branch unit.
// Branch type codes, BTB entry layout, 2-bit counter states.
package branch_resolve_btb_pkg;

  localparam logic [2:0] B_EQNE = 3'd0;
  localparam logic [2:0] B_LTGE = 3'd1;
  localparam logic [2:0] B_JUMP = 3'd2;
  localparam logic [2:0] B_JREG = 3'd3;

  localparam logic [1:0] SN = 2'b00;
  localparam logic [1:0] WN = 2'b01;
  localparam logic [1:0] WT = 2'b10;
  localparam logic [1:0] ST = 2'b11;

  // tag is kept right-aligned in a full word so the layout
  // does not depend on the BTB depth
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
    logic [1:0]  ctr;
  } btb_entry_t;

  function automatic logic [31:0] pc_tag(
    input logic [31:0] pc,
    input int          idx_w
  );
    return pc >> (idx_w + 2);
  endfunction

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == ST) ? ST : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == SN) ? SN : c - 2'd1;
  endfunction

endpackage

// File: rtl/branch_resolve_btb_if.sv
// IF lookup, EX resolve and redirect/perf bundle of the
// branch unit; master is the pipeline, slave the unit.
interface branch_resolve_btb_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      lookup_pc;
  logic             lookup_hit;
  logic             lookup_taken;
  logic [31:0]      lookup_target;
  logic             ex_valid;
  logic [31:0]      ex_pc;
  logic [31:0]      ex_instr;
  logic             ex_is_branch;
  logic [2:0]       ex_branch_type;
  logic [31:0]      ex_rs;
  logic [31:0]      ex_rt;
  logic             ex_pred_taken;
  logic [31:0]      ex_pred_target;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  modport master (
    output lookup_pc, ex_valid, ex_pc, ex_instr,
    output ex_is_branch, ex_branch_type, ex_rs, ex_rt,
    output ex_pred_taken, ex_pred_target,
    input  lookup_hit, lookup_taken, lookup_target,
    input  redirect_valid, redirect_pc,
    input  branch_count, mispredict_count
  );

  modport slave (
    input  lookup_pc, ex_valid, ex_pc, ex_instr,
    input  ex_is_branch, ex_branch_type, ex_rs, ex_rt,
    input  ex_pred_taken, ex_pred_target,
    output lookup_hit, lookup_taken, lookup_target,
    output redirect_valid, redirect_pc,
    output branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_resolve_btb_outcome.sv
// Combinational branch outcome: taken flag and taken target.
// Fall-through selection is left to the caller.
module branch_outcome
  import branch_resolve_btb_pkg::*;
(
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_instr_i,
  input  logic        ex_is_branch_i,
  input  logic [2:0]  ex_branch_type_i,
  input  logic [31:0] ex_rs_i,
  input  logic [31:0] ex_rt_i,
  output logic        taken_o,
  output logic [31:0] target_o
);

  logic [31:0] pc4;
  logic [31:0] imm_off;
  logic        rs_zero;
  logic        rs_neg;

  assign pc4     = ex_pc_i + 32'd4;
  assign imm_off = {{14{ex_instr_i[15]}}, ex_instr_i[15:0], 2'b00};
  assign rs_zero = (ex_rs_i == 32'd0);
  assign rs_neg  = ex_rs_i[31];

  // decode condition and target per branch class
  always_comb begin
    taken_o  = 1'b0;
    target_o = pc4 + imm_off;
    if (ex_is_branch_i) begin
      unique case (ex_branch_type_i)
        B_EQNE: begin
          unique case (ex_instr_i[27:26])
            2'b00: taken_o = (ex_rs_i == ex_rt_i);
            2'b01: taken_o = (ex_rs_i != ex_rt_i);
            2'b10: taken_o = rs_neg | rs_zero;
            2'b11: taken_o = ~rs_neg & ~rs_zero;
            default: taken_o = 1'b0;
          endcase
        end
        B_LTGE: taken_o = ex_instr_i[16] ? ~rs_neg : rs_neg;
        B_JUMP: begin
          taken_o  = 1'b1;
          target_o = {pc4[31:28], ex_instr_i[25:0], 2'b00};
        end
        B_JREG: begin
          taken_o  = 1'b1;
          target_o = ex_rs_i;
        end
        default: taken_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_btb.sv
// EX branch unit: resolves branches, issues one-cycle redirect
// on mispredict, owns the direct-mapped BTB and perf counters.
module branch_resolve_btb
  import branch_resolve_btb_pkg::*;
#(
  parameter int         BTB_DEPTH  = 16,
  parameter int         CNT_W      = 32,
  parameter logic [1:0] INIT_CTR   = 2'b10,
  parameter int         ENABLE_BTB = 1
) (
  input logic clk,
  input logic rst_n,
  input logic stall_i,
  branch_resolve_btb_if.slave bus
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam bit EN    = (ENABLE_BTB != 0);

  btb_entry_t       btb_q [BTB_DEPTH];
  logic             redir_v_q, redir_v_d;
  logic [31:0]      redir_pc_q, redir_pc_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;

  logic             act_taken;
  logic [31:0]      act_target;
  logic             mispredict;
  logic             fire;
  btb_entry_t       lk_ent;
  logic [IDX_W-1:0] ex_idx;
  btb_entry_t       ex_ent;
  logic             ex_hit;
  logic             wr_en;
  btb_entry_t       wr_entry;

  branch_outcome u_outcome (
    .ex_pc_i          (bus.ex_pc),
    .ex_instr_i       (bus.ex_instr),
    .ex_is_branch_i   (bus.ex_is_branch),
    .ex_branch_type_i (bus.ex_branch_type),
    .ex_rs_i          (bus.ex_rs),
    .ex_rt_i          (bus.ex_rt),
    .taken_o          (act_taken),
    .target_o         (act_target)
  );

  assign mispredict = (act_taken != bus.ex_pred_taken) |
                      (act_taken & (act_target != bus.ex_pred_target));
  assign fire = bus.ex_valid & ~stall_i;

  // IF-side lookup reads the array as it stands this cycle
  always_comb begin
    lk_ent = btb_q[bus.lookup_pc[IDX_W+1:2]];
    bus.lookup_hit = EN && lk_ent.valid &&
                     (lk_ent.tag == pc_tag(bus.lookup_pc, IDX_W));
    bus.lookup_taken  = bus.lookup_hit & lk_ent.ctr[1];
    bus.lookup_target = lk_ent.target;
  end

  // BTB write: train on branches, drop entries that aliased
  always_comb begin
    ex_idx   = bus.ex_pc[IDX_W+1:2];
    ex_ent   = btb_q[ex_idx];
    ex_hit   = ex_ent.valid &&
               (ex_ent.tag == pc_tag(bus.ex_pc, IDX_W));
    wr_en    = 1'b0;
    wr_entry = ex_ent;
    if (EN && fire && bus.ex_is_branch) begin
      if (act_taken) begin
        wr_en           = 1'b1;
        wr_entry.target = act_target;
        if (ex_hit) begin
          wr_entry.ctr = ctr_inc(ex_ent.ctr);
        end else begin
          wr_entry.valid = 1'b1;
          wr_entry.tag   = pc_tag(bus.ex_pc, IDX_W);
          wr_entry.ctr   = (bus.ex_branch_type == B_JUMP ||
                            bus.ex_branch_type == B_JREG) ?
                           ST : INIT_CTR;
        end
      end else if (ex_hit) begin
        wr_en        = 1'b1;
        wr_entry.ctr = ctr_dec(ex_ent.ctr);
      end
    end else if (EN && fire && bus.ex_pred_taken && ex_hit) begin
      wr_en          = 1'b1;
      wr_entry.valid = 1'b0;
    end
  end

  // redirect pulse and saturating perf counters, frozen on stall
  always_comb begin
    redir_v_d  = redir_v_q;
    redir_pc_d = redir_pc_q;
    br_cnt_d   = br_cnt_q;
    mp_cnt_d   = mp_cnt_q;
    if (!stall_i) begin
      redir_v_d = bus.ex_valid & mispredict;
      if (bus.ex_valid & mispredict)
        redir_pc_d = act_taken ? act_target : bus.ex_pc + 32'd8;
      if (bus.ex_valid & bus.ex_is_branch & (br_cnt_q != '1))
        br_cnt_d = br_cnt_q + 1'b1;
      if (bus.ex_valid & mispredict & (mp_cnt_q != '1))
        mp_cnt_d = mp_cnt_q + 1'b1;
    end
  end

  // state registers; reset wins over stall
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      redir_v_q  <= 1'b0;
      redir_pc_q <= 32'd0;
      br_cnt_q   <= '0;
      mp_cnt_q   <= '0;
      for (int i = 0; i < BTB_DEPTH; i++)
        btb_q[i] <= '{valid: 1'b0, tag: 32'd0,
                      target: 32'd0, ctr: WN};
    end else begin
      redir_v_q  <= redir_v_d;
      redir_pc_q <= redir_pc_d;
      br_cnt_q   <= br_cnt_d;
      mp_cnt_q   <= mp_cnt_d;
      if (wr_en)
        btb_q[ex_idx] <= wr_entry;
    end
  end

  assign bus.redirect_valid   = redir_v_q;
  assign bus.redirect_pc      = redir_pc_q;
  assign bus.branch_count     = br_cnt_q;
  assign bus.mispredict_count = mp_cnt_q;

endmodule

// File: doc/branch_resolve_btb.md
Name: branch_resolve_btb

Overview:
- Next-generation ex-stage branch unit.
- Resolves the branch outcome (BEQ/BNE/BLEZ/BGTZ/BLTZ/BGEZ/J/JR) and compares it with the prediction made in IF.
- Issues a registered one-cycle redirect on mispredict.
- Owns a parametrised direct-mapped BTB with 2-bit counters. IF reads it combinationally. Resolution writes it. Saturating perf counters record branches and mispredicts.

Parameters:
BTB_DEPTH, 16, BTB entries; power of two, >=2
CNT_W, 32, width of perf counters
INIT_CTR, 2'b10, counter value written on new allocation
ENABLE_BTB, 1, 0 forces lookup_hit=0 (static not-taken); BTB is not written

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
stall  in  1  freeze all state this cycle
lookup_pc  in  32  IF fetch PC
lookup_hit  out  1  BTB tag match on a valid entry
lookup_taken  out  1  lookup_hit & ctr[1]
lookup_target  out  32  stored target
ex_valid  in  1  EX holds a live instruction
ex_pc  in  32  PC of the EX instruction
ex_instr  in  32  instruction word
ex_is_branch  in  1  instruction is a branch/jump
ex_branch_type  in  3  B_EQNE/B_LTGE/B_JUMP/B_JREG
ex_rs, ex_rt  in  32  forwarded operands
ex_pred_taken  in  1  IF prediction, carried down the pipe
ex_pred_target  in  32  IF predicted target
redirect_valid  out  1  registered one-cycle mispredict pulse
redirect_pc  out  32  correct fetch address
branch_count  out  CNT_W  resolved branches, saturating
mispredict_count  out  CNT_W  mispredicts, saturating

Behaviour:
- Reset (rst_n=0 at posedge):
  - All BTB valid bits cleared; counters set to 2'b01.
  - redirect_valid=0, redirect_pc=0, both perf counters 0.
  - Reset dominates stall.
- Index and tag: idx=pc[IDX_W+1:2], tag=pc[31:IDX_W+2], IDX_W=$clog2(BTB_DEPTH). Lookup is purely combinational.
- Outcome, combinational; imm_tgt = ex_pc+4+(sext(instr[15:0])<<2):
  - EQNE, selected by instr[27:26]: 00 BEQ rs==rt; 01 BNE rs!=rt; 10 BLEZ rs[31]|(rs==0); 11 BGTZ !rs[31]&(rs!=0).
  - LTGE, selected by instr[16]: 0 BLTZ rs[31]; 1 BGEZ !rs[31].
  - JUMP: always taken; target {ex_pc+4}[31:28],instr[25:0],00.
  - JREG: always taken; target rs.
  - Other branch_type values, or ex_is_branch=0: not taken.
  - Fall-through address = ex_pc+8 (delay slot already fetched).
- Mispredict, evaluated when ex_valid & !stall:
  - (actual_taken != ex_pred_taken), or (actual_taken & target != ex_pred_target).
  - Covers non-branches predicted taken (BTB alias); those redirect to ex_pc+8.
- Redirect timing: at the next posedge redirect_valid=1 and redirect_pc = actual target, or ex_pc+8 if not taken. With no mispredict, redirect_valid=0 the following cycle. It is never held more than one cycle unless stall is high.
- stall=1: redirect regs, BTB and perf counters all hold.
- BTB update, at posedge when ex_valid & ex_is_branch & !stall & ENABLE_BTB:
  - Taken, hit: write target; ctr saturating +1 (max 11).
  - Taken, miss: allocate; write tag and target, valid=1, ctr=INIT_CTR. JUMP/JREG write ctr=11.
  - Not taken, hit: ctr saturating -1 (min 00).
  - Not taken, miss: no allocation.
  - Non-branch mispredicted as taken, hit: invalidate the entry.
- Read-during-write to the same index: lookup sees the old entry; the new value is visible the following cycle.
- Perf counters:
  - branch_count +1 per resolved branch.
  - mispredict_count +1 per mispredict.
  - Both saturate at all-ones and do not wrap.
- Flushing wrong-path EX instructions (deasserting ex_valid) is the pipeline's job, not this block's.

Decomposition:
- Shared package holds:
  - B_* branch_type codes.
  - btb_entry_t {valid, tag, target, ctr[1:0]}.
  - Counter constants SN=00, WN=01, WT=10, ST=11.
- One natural sub-module, branch_outcome: purely combinational; ex inputs -> {taken, target}.
- The BTB array, update logic, redirect regs and perf counters stay in the top.

Test Plan:
- Reset, then lookup_pc=0x00400000 -> lookup_hit=0; all outputs 0.
- BEQ at 0x00400010, imm=0x0004, rs=rt=5, pred_taken=0 -> next cycle redirect_valid=1, redirect_pc=0x00400024. Lookup at 0x00400010 then hits with taken=1, ctr=10.
- Same BEQ repeated 3x taken, then rs!=rt with pred_taken=1 -> ctr walks 10->11->11, then 11->10; redirect_pc=0x00400018.
- JR with rs=0x80001000 and pred_target=0x80000000, pred_taken=1 -> mispredict; redirect_pc=0x80001000; BTB target updated.
- stall=1 held for 3 cycles during a mispredicting BEQ -> no redirect pulse and no BTB change until stall=0; then exactly one pulse.
- CNT_W=4: 17 mispredicts -> mispredict_count stays 0xF; rst_n=0 mid-sequence -> all state cleared next edge.
